meter_value_gen: RTL and testbench



---
 rtl/meter_value_gen.sv | 117 +++++++++++
 tb/tb_meter_value_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/meter_value_gen.sv
// Countdown value generator feeding the 4-digit seven-segment display driver.
// Button pulses adjust a 0..MAX_VAL count, sec_tick counts it down, and an FSM gates flashing.
module meter_value_gen #(
  parameter int unsigned MAX_VAL    = 9999,
  parameter int unsigned ADD_A      = 10,
  parameter int unsigned ADD_B      = 180,
  parameter int unsigned LOAD_A     = 15,
  parameter int unsigned LOAD_B     = 150,
  parameter int unsigned LOW_THRESH = 200
) (
  input  logic        slow_clk,
  input  logic        reset,
  input  logic        sec_tick,
  input  logic        btn_a,
  input  logic        btn_b,
  input  logic        btn_la,
  input  logic        btn_lb,
  input  logic        btn_mode,
  output logic [15:0] value,
  output logic        alt_mode,
  output logic        blank,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StRun     = 2'b01,
    StLow     = 2'b10,
    StExpired = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] value_q, value_d;
  logic        alt_mode_q, alt_mode_d;
  logic        blank_q, blank_d;
  logic [4:0]  btn_prev_q, btn_prev_d;

  logic [4:0]  btn_now;
  logic [4:0]  btn_fire;
  logic [16:0] sum;
  logic [15:0] inter;

  // Bit order: {mode, lb, la, b, a}
  assign btn_now    = {btn_mode, btn_lb, btn_la, btn_b, btn_a};
  assign btn_fire   = btn_now & ~btn_prev_q;
  assign btn_prev_d = btn_now;

  // State register (reset overrides every simultaneous event)
  always_ff @(posedge slow_clk) begin
    if (reset) begin
      state_q    <= StIdle;
      value_q    <= '0;
      alt_mode_q <= 1'b0;
      blank_q    <= 1'b0;
      btn_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      alt_mode_q <= alt_mode_d;
      blank_q    <= blank_d;
      btn_prev_q <= btn_prev_d;
    end
  end

  // Value datapath: load beats add; the tick decrement applies on top of either
  always_comb begin
    sum = {1'b0, value_q};
    if (btn_fire[0]) sum = sum + 17'(ADD_A);
    if (btn_fire[1]) sum = sum + 17'(ADD_B);

    if (btn_fire[3]) begin
      inter = 16'(LOAD_B);
    end else if (btn_fire[2]) begin
      inter = 16'(LOAD_A);
    end else if (sum > 17'(MAX_VAL)) begin
      inter = 16'(MAX_VAL);
    end else begin
      inter = sum[15:0];
    end

    value_d = inter;
    if (sec_tick && (state_q == StRun || state_q == StLow) && inter != 16'd0) begin
      value_d = inter - 16'd1;
    end

    alt_mode_d = alt_mode_q ^ btn_fire[4];
  end

  // Next-state logic, driven by the next value
  always_comb begin
    state_d = state_q;
    if (value_d == 16'd0) begin
      state_d = (state_q == StIdle) ? StIdle : StExpired;
    end else if (value_d < 16'(LOW_THRESH)) begin
      state_d = StLow;
    end else begin
      state_d = StRun;
    end
  end

  // Flash gating: LOW enters lit, EXPIRED enters dark, both toggle per tick while resident
  always_comb begin
    blank_d = 1'b0;
    unique case (state_d)
      StIdle, StRun: blank_d = 1'b0;
      StLow:         blank_d = (state_q == StLow) ? (blank_q ^ sec_tick) : 1'b0;
      StExpired:     blank_d = (state_q == StExpired) ? (blank_q ^ sec_tick) : 1'b1;
      default:       blank_d = 1'b0;
    endcase
  end

  assign value    = value_q;
  assign alt_mode = alt_mode_q;
  assign blank    = blank_q;
  assign state    = state_q;

endmodule

// File: tb/tb_meter_value_gen.sv
// Scoreboard bench for meter_value_gen: stimulus pushes expected outputs per edge,
// a monitor pops and compares them one time unit after each rising edge.
module tb_meter_value_gen;

  localparam logic [1:0] StIdle    = 2'b00;
  localparam logic [1:0] StRun     = 2'b01;
  localparam logic [1:0] StLow     = 2'b10;
  localparam logic [1:0] StExpired = 2'b11;

  // Input mask bits: {reset, tick, mode, lb, la, b, a}
  localparam logic [6:0] A  = 7'h01;
  localparam logic [6:0] B  = 7'h02;
  localparam logic [6:0] LA = 7'h04;
  localparam logic [6:0] LB = 7'h08;
  localparam logic [6:0] MD = 7'h10;
  localparam logic [6:0] TK = 7'h20;
  localparam logic [6:0] RS = 7'h40;

  logic        slow_clk;
  logic        reset;
  logic        sec_tick;
  logic        btn_a, btn_b, btn_la, btn_lb, btn_mode;
  logic [15:0] value;
  logic        alt_mode;
  logic        blank;
  logic [1:0]  state;

  typedef struct {
    int          stamp;
    logic [15:0] v;
    logic [1:0]  s;
    logic        bl;
    logic        am;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  int   cyc;
  int   n_issued;
  int   n_total;
  int   n_pass;
  logic am_exp;

  meter_value_gen dut (
    .slow_clk (slow_clk),
    .reset    (reset),
    .sec_tick (sec_tick),
    .btn_a    (btn_a),
    .btn_b    (btn_b),
    .btn_la   (btn_la),
    .btn_lb   (btn_lb),
    .btn_mode (btn_mode),
    .value    (value),
    .alt_mode (alt_mode),
    .blank    (blank),
    .state    (state)
  );

  initial begin
    slow_clk = 1'b0;
    forever #5 slow_clk = ~slow_clk;
  end

  // Monitor: compare every expectation stamped for the edge just taken
  initial begin
    exp_t e;
    cyc = 0;
    forever begin
      @(posedge slow_clk);
      cyc++;
      #1;
      while (sb_q.size() > 0 && sb_q[0].stamp <= cyc) begin
        e = sb_q.pop_front();
        n_total++;
        if (e.stamp != cyc) begin
          $display("FAIL chk#%0d: missed (stamp %0d, now %0d)", e.id, e.stamp, cyc);
        end else if (value !== e.v || state !== e.s || blank !== e.bl || alt_mode !== e.am) begin
          $display("FAIL chk#%0d: got value=%0d state=%b blank=%b alt=%b, want value=%0d state=%b blank=%b alt=%b",
                   e.id, value, state, blank, alt_mode, e.v, e.s, e.bl, e.am);
        end else begin
          n_pass++;
        end
      end
    end
  end

  function automatic logic [1:0] st_of(input int v);
    return (v < 200) ? StLow : StRun;
  endfunction

  // Drive one cycle of inputs and expect the outputs after the following edge
  task automatic step(input logic [6:0] m, input int v, input logic [1:0] s, input logic bl);
    {reset, sec_tick, btn_mode, btn_lb, btn_la, btn_b, btn_a} = m;
    sb_q.push_back('{cyc + 1, 16'(v), s, bl, am_exp, n_issued});
    n_issued++;
    @(negedge slow_clk);
  endtask

  task automatic press(input logic [6:0] m, input int v, input logic [1:0] s, input logic bl);
    step(m, v, s, bl);
    step(7'h00, v, s, bl);
  endtask

  // Reset, then n presses of btn_b from 0
  task automatic fill_b(input int n);
    step(RS, 0, StIdle, 1'b0);
    for (int k = 1; k <= n; k++) press(B, 180 * k, st_of(180 * k), 1'b0);
  endtask

  initial begin
    logic bexp;
    int   v;
    n_issued = 0;
    n_total  = 0;
    n_pass   = 0;
    am_exp   = 1'b0;
    {reset, sec_tick, btn_mode, btn_lb, btn_la, btn_b, btn_a} = RS;
    @(negedge slow_clk);

    step(RS, 0, StIdle, 1'b0);
    step(7'h00, 0, StIdle, 1'b0);

    // Three separate btn_a presses, then a long hold counts once
    press(A, 10, StLow, 1'b0);
    press(A, 20, StLow, 1'b0);
    press(A, 30, StLow, 1'b0);
    for (int i = 0; i < 20; i++) step(A, 40, StLow, 1'b0);
    step(7'h00, 40, StLow, 1'b0);

    // Load 150 then count down to expiry and beyond
    press(LB, 150, StLow, 1'b0);
    bexp = 1'b0;
    for (int i = 1; i <= 150; i++) begin
      v = 150 - i;
      if (v > 0) begin
        bexp = ~bexp;
        step(TK, v, StLow, bexp);
      end else begin
        bexp = 1'b1;
        step(TK, 0, StExpired, 1'b1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      bexp = ~bexp;
      step(TK, 0, StExpired, bexp);
    end
    step(7'h00, 0, StExpired, bexp);

    // Saturation
    fill_b(55);
    for (int j = 1; j <= 9; j++) press(A, 9900 + 10 * j, StRun, 1'b0);
    press(B, 9999, StRun, 1'b0);
    fill_b(50);
    press(A | B, 9190, StRun, 1'b0);
    fill_b(55);
    press(A | B, 9999, StRun, 1'b0);

    // Load priority over add, LOAD_B over LOAD_A
    fill_b(2);
    for (int j = 1; j <= 14; j++) press(A, 360 + 10 * j, StRun, 1'b0);
    press(LA | LB | A, 150, StLow, 1'b0);

    // Tick together with add at 200
    for (int j = 1; j <= 5; j++) press(A, 150 + 10 * j, st_of(150 + 10 * j), 1'b0);
    press(A | TK, 209, StRun, 1'b0);

    // Lone ticks across the LOW threshold
    fill_b(1);
    press(A, 190, StLow, 1'b0);
    press(A, 200, StRun, 1'b0);
    press(TK, 199, StLow, 1'b0);
    press(TK, 198, StLow, 1'b1);

    // alt_mode toggling
    am_exp = 1'b1;
    press(MD, 198, StLow, 1'b1);
    am_exp = 1'b0;
    press(MD, 198, StLow, 1'b1);

    // Reset while running overrides simultaneous add and tick
    fill_b(1);
    for (int j = 1; j <= 12; j++) press(A, 180 + 10 * j, st_of(180 + 10 * j), 1'b0);
    am_exp = 1'b1;
    press(MD, 300, StRun, 1'b0);
    am_exp = 1'b0;
    step(RS | A | TK, 0, StIdle, 1'b0);
    step(7'h00, 0, StIdle, 1'b0);

    repeat (3) @(negedge slow_clk);
    if (sb_q.size() != 0) begin
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
      n_total += sb_q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
